// File: rtl/prog_loader_pkg.sv
// ============================================================================
// Module  : prog_loader_pkg
// Brief   : Shared constants for the byte-stream memory-image loader.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package prog_loader_pkg;

  // Frame FSM encoding
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ADDR_HI = 3'd1;
  localparam logic [2:0] S_ADDR_LO = 3'd2;
  localparam logic [2:0] S_CNT_HI  = 3'd3;
  localparam logic [2:0] S_CNT_LO  = 3'd4;
  localparam logic [2:0] S_DATA    = 3'd5;
  localparam logic [2:0] S_WRITE   = 3'd6;
  localparam logic [2:0] S_RUN     = 3'd7;

  localparam logic [7:0] HDR_IM_DEF = 8'hA5;
  localparam logic [7:0] HDR_DM_DEF = 8'h5A;
  localparam logic [7:0] HDR_GO_DEF = 8'hC3;

  // Width of a byte-within-word counter; never narrower than one bit.
  function automatic int bcnt_w(input int data_w);
    return (data_w / 8 > 1) ? $clog2(data_w / 8) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/prog_loader_word_assembler.sv
// ============================================================================
// Module  : prog_loader_word_assembler
// Brief   : Big-endian byte-to-word shift register with end-of-word flag.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module prog_loader_word_assembler
  import prog_loader_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        byte_i,
  input  logic              byte_valid_i,
  output logic [DATA_W-1:0] word_o,
  output logic              word_done_o
);

  localparam int                 BPW    = DATA_W / 8;
  localparam int                 BCNT_W = bcnt_w(DATA_W);
  localparam logic [BCNT_W-1:0]  LAST   = BCNT_W'(BPW - 1);

  logic [BCNT_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [DATA_W-1:0] shifted;

  generate
    if (DATA_W > 8) begin : g_shift
      assign shifted = {word_q[DATA_W-9:0], byte_i};
    end else begin : g_byte
      assign shifted = byte_i;
    end
  endgenerate

  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (byte_valid_i) begin
      word_d = shifted;
      cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  assign word_o      = word_q;
  assign word_done_o = byte_valid_i && (cnt_q == LAST);

endmodule

`default_nettype wire

// File: rtl/prog_loader.sv
// ============================================================================
// Module  : prog_loader
// Brief   : Loads framed IM/DM images from a byte stream, then releases CPU.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int         ADDR_W = 12,
  parameter int         DATA_W = 32,
  parameter logic [7:0] HDR_IM = HDR_IM_DEF,
  parameter logic [7:0] HDR_DM = HDR_DM_DEF,
  parameter logic [7:0] HDR_GO = HDR_GO_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              im_w_en,
  output logic              dm_w_en,
  output logic [ADDR_W-1:0] w_addr,
  output logic [DATA_W-1:0] w_data,
  output logic              cpu_rst,
  output logic              loading,
  output logic              err
);

  logic [2:0]        state_q, state_d;
  logic              tgt_dm_q, tgt_dm_d;
  logic [7:0]        hi_q, hi_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              xfer;
  logic              word_done;

  assign in_ready = (state_q != S_WRITE) && (state_q != S_RUN);
  assign xfer     = in_valid && in_ready;

  prog_loader_word_assembler #(
    .DATA_W (DATA_W)
  ) u_asm (
    .clk          (clk),
    .rst          (rst),
    .byte_i       (in_data),
    .byte_valid_i (xfer && (state_q == S_DATA)),
    .word_o       (w_data),
    .word_done_o  (word_done)
  );

  always_comb begin
    state_d  = state_q;
    tgt_dm_d = tgt_dm_q;
    hi_d     = hi_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: if (xfer) begin
        if (in_data == HDR_IM) begin
          tgt_dm_d = 1'b0;
          state_d  = S_ADDR_HI;
        end else if (in_data == HDR_DM) begin
          tgt_dm_d = 1'b1;
          state_d  = S_ADDR_HI;
        end else if (in_data == HDR_GO) begin
          state_d  = S_RUN;
        end else begin
          err_d    = 1'b1;
        end
      end
      S_ADDR_HI: if (xfer) begin
        hi_d    = in_data;
        state_d = S_ADDR_LO;
      end
      // Only the low ADDR_W bits of the 16-bit address field are kept.
      S_ADDR_LO: if (xfer) begin
        addr_d  = ADDR_W'({hi_q, in_data});
        state_d = S_CNT_HI;
      end
      S_CNT_HI: if (xfer) begin
        hi_d    = in_data;
        state_d = S_CNT_LO;
      end
      S_CNT_LO: if (xfer) begin
        cnt_d   = {hi_q, in_data};
        state_d = ({hi_q, in_data} == 16'd0) ? S_IDLE : S_DATA;
      end
      S_DATA: if (word_done) state_d = S_WRITE;
      S_WRITE: begin
        addr_d  = addr_q + 1'b1;
        cnt_d   = cnt_q - 16'd1;
        state_d = (cnt_q == 16'd1) ? S_IDLE : S_DATA;
      end
      S_RUN:   state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      tgt_dm_q <= 1'b0;
      hi_q     <= 8'd0;
      addr_q   <= '0;
      cnt_q    <= 16'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tgt_dm_q <= tgt_dm_d;
      hi_q     <= hi_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  assign im_w_en = (state_q == S_WRITE) && !tgt_dm_q;
  assign dm_w_en = (state_q == S_WRITE) &&  tgt_dm_q;
  assign w_addr  = addr_q;
  assign cpu_rst = (state_q != S_RUN);
  assign loading = (state_q != S_RUN);
  assign err     = err_q;

endmodule

`default_nettype wire

// File: tb/tb_prog_loader.sv
// ============================================================================
// Module  : tb_prog_loader
// Brief   : Self-checking bench for prog_loader (vector table + sequences).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        im_w_en;
  logic        dm_w_en;
  logic [11:0] w_addr;
  logic [31:0] w_data;
  logic        cpu_rst;
  logic        loading;
  logic        err;

  prog_loader dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .im_w_en  (im_w_en),
    .dm_w_en  (dm_w_en),
    .w_addr   (w_addr),
    .w_data   (w_data),
    .cpu_rst  (cpu_rst),
    .loading  (loading),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        dm;
    logic [11:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [7:0]  hdr;
    logic [15:0] addr16;
    logic [31:0] data;
    logic        exp_dm;
    logic [11:0] exp_addr;
  } vec_t;

  int  checks = 0;
  int  errors = 0;
  bit  rnd_gap = 0;
  bit  prev_strobe = 0;
  wr_t wr_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Write-port monitor: captures strobes and checks per-strobe invariants.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (im_w_en || dm_w_en) begin
        chk("ready_in_strobe", in_ready, 0);
        chk("strobe_onehot", im_w_en & dm_w_en, 0);
        chk("strobe_1cyc", prev_strobe, 0);
        wr_q.push_back('{dm: dm_w_en, addr: w_addr, data: w_data});
      end
      prev_strobe = im_w_en || dm_w_en;
    end else begin
      prev_strobe = 0;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    if (rnd_gap) begin
      int g = $urandom_range(0, 3);
      repeat (g) @(negedge clk);
    end
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("handshake_timeout", 1, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_hdr(input logic [7:0] h, input logic [15:0] a, input logic [15:0] c);
    send_byte(h);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
    send_byte(c[15:8]);
    send_byte(c[7:0]);
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic expect_wr(input string tag, input logic dm, input logic [11:0] a, input logic [31:0] d);
    wr_t w;
    if (wr_q.size() == 0) begin
      chk({tag, "_present"}, 0, 1);
    end else begin
      w = wr_q.pop_front();
      chk({tag, "_sel"}, w.dm, dm);
      chk({tag, "_addr"}, w.addr, a);
      chk({tag, "_data"}, w.data, d);
    end
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset(input bit check);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    if (check) begin
      chk("rst_in_ready", in_ready, 1);
      chk("rst_im_w_en", im_w_en, 0);
      chk("rst_dm_w_en", dm_w_en, 0);
      chk("rst_w_addr", w_addr, 0);
      chk("rst_w_data", w_data, 0);
      chk("rst_cpu_rst", cpu_rst, 1);
      chk("rst_loading", loading, 1);
      chk("rst_err", err, 0);
    end
    @(negedge clk);
    rst = 1'b1;
    wr_q.delete();
  endtask

  task automatic frame1(input string tag);
    send_hdr(8'hA5, 16'h0010, 16'h0002);
    send_word(32'h0000_0013);
    chk({tag, "_latency"}, im_w_en, 1);
    send_word(32'h0010_0093);
    chk({tag, "_latency2"}, im_w_en, 1);
    settle();
    chk({tag, "_nwr"}, wr_q.size(), 2);
    expect_wr({tag, "_w0"}, 0, 12'h010, 32'h0000_0013);
    expect_wr({tag, "_w1"}, 0, 12'h011, 32'h0010_0093);
    chk({tag, "_cpu_rst"}, cpu_rst, 1);
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{8'hA5, 16'h0000, 32'hDEAD_BEEF, 1'b0, 12'h000};
    vecs[1] = '{8'h5A, 16'h0ABC, 32'h0000_0001, 1'b1, 12'hABC};
    vecs[2] = '{8'hA5, 16'hF123, 32'h8000_0000, 1'b0, 12'h123};
    vecs[3] = '{8'h5A, 16'h0FFF, 32'hA5A5_A5A5, 1'b1, 12'hFFF};
    vecs[4] = '{8'hA5, 16'h1000, 32'h0F0F_0F0F, 1'b0, 12'h000};

    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    do_reset(1);

    // Single-word frames from the vector table
    for (int i = 0; i < 5; i++) begin
      send_hdr(vecs[i].hdr, vecs[i].addr16, 16'h0001);
      send_word(vecs[i].data);
      settle();
      chk($sformatf("vec%0d_nwr", i), wr_q.size(), 1);
      expect_wr($sformatf("vec%0d", i), vecs[i].exp_dm, vecs[i].exp_addr, vecs[i].data);
    end

    // 1: two-word IM frame
    frame1("t1");

    // 2: DM frame wrapping the address
    send_hdr(8'h5A, 16'h0FFF, 16'h0002);
    send_word(32'hFFFF_FFFF);
    send_word(32'h1234_5678);
    settle();
    chk("t2_nwr", wr_q.size(), 2);
    expect_wr("t2_w0", 1, 12'hFFF, 32'hFFFF_FFFF);
    expect_wr("t2_w1", 1, 12'h000, 32'h1234_5678);

    // 3: unknown header sets sticky err
    send_byte(8'h77);
    chk("t3_err_set", err, 1);
    settle();
    chk("t3_no_strobe", wr_q.size(), 0);
    send_hdr(8'hA5, 16'h0042, 16'h0001);
    send_word(32'hCAFE_F00D);
    settle();
    expect_wr("t3_w0", 0, 12'h042, 32'hCAFE_F00D);
    chk("t3_err_sticky", err, 1);

    // 4: empty frame, then GO
    send_hdr(8'h5A, 16'h0000, 16'h0000);
    settle();
    chk("t4_empty_nwr", wr_q.size(), 0);
    chk("t4_pre_cpu_rst", cpu_rst, 1);
    chk("t4_pre_loading", loading, 1);
    send_byte(8'hC3);
    chk("t4_cpu_rst", cpu_rst, 0);
    chk("t4_loading", loading, 0);
    chk("t4_in_ready", in_ready, 0);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'hA5;
    repeat (12) begin
      @(negedge clk);
      in_data = in_data + 8'h11;
    end
    in_valid = 1'b0;
    chk("t4_ignored_nwr", wr_q.size(), 0);
    chk("t4_still_run", cpu_rst, 0);
    chk("t4_still_ready0", in_ready, 0);

    // 5: reset in the middle of a word
    do_reset(0);
    send_byte(8'h66);
    send_hdr(8'hA5, 16'h0020, 16'h0001);
    send_byte(8'h11);
    send_byte(8'h22);
    do_reset(1);
    chk("t5_no_strobe", wr_q.size(), 0);
    send_hdr(8'h5A, 16'h0033, 16'h0001);
    send_word(32'h0BAD_CAFE);
    settle();
    chk("t5_nwr", wr_q.size(), 1);
    expect_wr("t5_w0", 1, 12'h033, 32'h0BAD_CAFE);

    // 6: frame 1 again with random valid gaps
    rnd_gap = 1;
    send_hdr(8'hA5, 16'h0010, 16'h0002);
    send_word(32'h0000_0013);
    send_word(32'h0010_0093);
    rnd_gap = 0;
    settle();
    chk("t6_nwr", wr_q.size(), 2);
    expect_wr("t6_w0", 0, 12'h010, 32'h0000_0013);
    expect_wr("t6_w1", 0, 12'h011, 32'h0010_0093);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
